// File: rtl/cache_pkg.sv
// Shared geometry and state encoding for the direct-mapped cache controller.
// Address layout: tag[14:12], index[11:2], offset[1:0].
package cache_pkg;

  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 32;
  localparam int TAG_W    = 3;
  localparam int INDEX_W  = 10;
  localparam int OFFSET_W = 2;
  localparam int LINES    = 1024;
  localparam int WORDS    = 4;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    FILL      = 2'd2,
    WRITE_MEM = 2'd3
  } state_t;

  typedef logic [WORDS-1:0][DATA_W-1:0] line_t;

endpackage

// File: rtl/cache_line_array.sv
// Tag/valid/data storage: combinational index read port, whole-line fill port,
// single-word write port. Only the valid bits are cleared by reset.
module cache_line_array
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_W-1:0]  rd_index,
  input  logic [OFFSET_W-1:0] rd_offset,
  output logic                rd_valid,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [DATA_W-1:0]   rd_word,
  input  logic                fill_en,
  input  logic [INDEX_W-1:0]  fill_index,
  input  logic [TAG_W-1:0]    fill_tag,
  input  line_t               fill_line,
  input  logic                word_en,
  input  logic [INDEX_W-1:0]  word_index,
  input  logic [OFFSET_W-1:0] word_offset,
  input  logic [DATA_W-1:0]   word_data
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES*WORDS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_index] <= 1'b1;
    end
  end

  // Fill and word write never coincide: fills happen in FILL, word updates in COMPARE.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_index] <= fill_tag;
      for (int w = 0; w < WORDS; w++) begin
        data_q[{fill_index, OFFSET_W'(w)}] <= fill_line[w];
      end
    end else if (word_en) begin
      data_q[{word_index, word_offset}] <= word_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_word  = data_q[{rd_index, rd_offset}];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Define CACHE_STATS_EN to add saturating read hit/miss counters.
module cache_controller
  import cache_pkg::*;
#(
  parameter int MEM_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_writeData,
  input  logic              cpu_read,
  input  logic              cpu_write,
  output logic [DATA_W-1:0] cpu_readData,
  output logic              ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_readData1,
  input  logic [DATA_W-1:0] mem_readData2,
  input  logic [DATA_W-1:0] mem_readData3,
  input  logic [DATA_W-1:0] mem_readData4,
  output state_t            state
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LATENCY - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                write_q;

  logic [TAG_W-1:0]    tag_a;
  logic [INDEX_W-1:0]  index_a;
  logic [OFFSET_W-1:0] offset_a;
  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [DATA_W-1:0]   rd_word;
  logic                hit;
  logic                fill_en;
  logic                word_en;

  assign tag_a    = addr_q[ADDR_W-1 -: TAG_W];
  assign index_a  = addr_q[OFFSET_W +: INDEX_W];
  assign offset_a = addr_q[OFFSET_W-1:0];
  assign hit      = rd_valid && (rd_tag == tag_a);
  assign state    = state_q;

  cache_line_array u_lines (
    .clk         (clk),
    .rst         (rst),
    .rd_index    (index_a),
    .rd_offset   (offset_a),
    .rd_valid    (rd_valid),
    .rd_tag      (rd_tag),
    .rd_word     (rd_word),
    .fill_en     (fill_en),
    .fill_index  (index_a),
    .fill_tag    (tag_a),
    .fill_line   ({mem_readData4, mem_readData3, mem_readData2, mem_readData1}),
    .word_en     (word_en),
    .word_index  (index_a),
    .word_offset (offset_a),
    .word_data   (wdata_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Reload on every state change; otherwise count down and park at zero.
      if (state_d != state_q) begin
        cnt_q <= LAT_INIT;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (state_q == IDLE && (cpu_read || cpu_write)) begin
        addr_q  <= cpu_address;
        wdata_q <= cpu_writeData;
        write_q <= cpu_write;
      end
    end
  end

  // Outputs are decoded from the registered state, so async reset clears them at once.
  always_comb begin
    state_d       = state_q;
    ready         = 1'b0;
    cpu_readData  = '0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writeData = '0;
    fill_en       = 1'b0;
    word_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_read || cpu_write) state_d = COMPARE;
      end
      COMPARE: begin
        if (write_q) begin
          word_en = hit;
          state_d = WRITE_MEM;
        end else if (hit) begin
          ready        = 1'b1;
          cpu_readData = rd_word;
          state_d      = IDLE;
        end else begin
          state_d = FILL;
        end
      end
      FILL: begin
        mem_read    = 1'b1;
        mem_address = {tag_a, index_a, {OFFSET_W{1'b0}}};
        if (cnt_q == '0) begin
          fill_en = 1'b1;
          state_d = COMPARE;
        end
      end
      WRITE_MEM: begin
        mem_write     = 1'b1;
        mem_address   = addr_q;
        mem_writeData = wdata_q;
        if (cnt_q == '0) begin
          ready   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CACHE_STATS_EN
  // The COMPARE that follows a fill always hits and is excluded from the stats.
  logic post_fill_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      post_fill_q <= 1'b0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      post_fill_q <= (state_q == FILL);
      if (state_q == COMPARE && !write_q && !post_fill_q) begin
        if (hit) begin
          if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
        end else begin
          if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: word-addressed memory model with RAM[i]=i,
// hand-computed latencies, data and memory-strobe counts per request.
module tb_cache_controller;
  import cache_pkg::*;

  logic        clk;
  logic        rst;
  logic [14:0] cpu_address;
  logic [31:0] cpu_writeData;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_readData;
  logic        ready;
  logic [14:0] mem_address;
  logic [31:0] mem_writeData;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_readData1, mem_readData2, mem_readData3, mem_readData4;
  state_t      state;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] ram [32768];

  cache_controller #(.MEM_LATENCY(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_address   (cpu_address),
    .cpu_writeData (cpu_writeData),
    .cpu_read      (cpu_read),
    .cpu_write     (cpu_write),
    .cpu_readData  (cpu_readData),
    .ready         (ready),
    .mem_address   (mem_address),
    .mem_writeData (mem_writeData),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_readData1 (mem_readData1),
    .mem_readData2 (mem_readData2),
    .mem_readData3 (mem_readData3),
    .mem_readData4 (mem_readData4),
    .state         (state)
`ifdef CACHE_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = i;
  end

  assign mem_readData1 = ram[mem_address];
  assign mem_readData2 = ram[15'(mem_address + 15'd1)];
  assign mem_readData3 = ram[15'(mem_address + 15'd2)];
  assign mem_readData4 = ram[15'(mem_address + 15'd3)];

  always @(posedge clk) begin
    if (mem_write) ram[mem_address] <= mem_writeData;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request and observe it cycle by cycle (cycle 1 = the IDLE cycle).
  task automatic do_req(input string name, input logic rd, input logic wr,
                        input logic [14:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input logic [31:0] exp_data,
                        input int exp_nrd, input int exp_nwr);
    int          lat;
    int          nrd;
    int          nwr;
    int          bad;
    logic [31:0] rdata;
    lat = -1; nrd = 0; nwr = 0; bad = 0; rdata = '0;
    @(posedge clk); #1;
    cpu_address   = addr;
    cpu_writeData = wdata;
    cpu_read      = rd;
    cpu_write     = wr;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mem_read) begin
        nrd++;
        if (mem_address !== {addr[14:2], 2'b00}) bad++;
      end
      if (mem_write) begin
        nwr++;
        if (mem_address !== addr || mem_writeData !== wdata) bad++;
      end
      if (ready) begin
        lat   = c;
        rdata = cpu_readData;
        break;
      end else if (cpu_readData !== 32'd0) begin
        bad++;
      end
    end
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    check({name, ".latency"}, lat, exp_lat);
    check({name, ".mem_read_cycles"}, nrd, exp_nrd);
    check({name, ".mem_write_cycles"}, nwr, exp_nwr);
    check({name, ".bus_violations"}, bad, 0);
    if (rd && !wr) check({name, ".data"}, rdata, exp_data);
  endtask

  initial begin
    rst = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0;
    cpu_address = '0; cpu_writeData = '0;
    repeat (2) @(negedge clk);
    check("reset.state", state, IDLE);
    check("reset.ready", ready, 0);
    check("reset.mem_strobes", {mem_read, mem_write}, 0);
    check("reset.mem_address", mem_address, 0);
    check("reset.mem_writeData", mem_writeData, 0);
    check("reset.cpu_readData", cpu_readData, 0);
`ifdef CACHE_STATS_EN
    check("reset.hit_count", hit_count, 0);
    check("reset.miss_count", miss_count, 0);
`endif
    rst = 1'b0;

    do_req("cold_0400", 1, 0, 15'h0400, 0, 7, 32'd1024, 4, 0);
    do_req("hit_0403",  1, 0, 15'h0403, 0, 2, 32'd1027, 0, 0);
`ifdef CACHE_STATS_EN
    @(negedge clk);
    check("stats.hit_count", hit_count, 1);
    check("stats.miss_count", miss_count, 1);
`endif
    do_req("conflict_1401", 1, 0, 15'h1401, 0, 7, 32'd5121, 4, 0);
    do_req("evicted_0401",  1, 0, 15'h0401, 0, 7, 32'd1025, 4, 0);
    do_req("wr_hit_0402",   0, 1, 15'h0402, 32'hDEADBEEF, 6, 0, 0, 4);
    do_req("rd_0402",       1, 0, 15'h0402, 0, 2, 32'hDEADBEEF, 0, 0);
    do_req("wr_miss_2000",  0, 1, 15'h2000, 32'h12345678, 6, 0, 0, 4);
    do_req("rd_2000",       1, 0, 15'h2000, 0, 7, 32'h12345678, 4, 0);
    do_req("both_0403",     1, 1, 15'h0403, 32'hA5A5A5A5, 6, 0, 0, 4);
    do_req("rd_0403",       1, 0, 15'h0403, 0, 2, 32'hA5A5A5A5, 0, 0);

    // Reset on the second FILL cycle of a miss to 0x1800.
    @(posedge clk); #1;
    cpu_address = 15'h1800;
    cpu_read    = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_fill.mem_read_before", mem_read, 1);
    check("rst_fill.state_before", state, FILL);
    rst = 1'b1;
    #1;
    check("rst_fill.mem_read", mem_read, 0);
    check("rst_fill.state", state, IDLE);
    check("rst_fill.mem_address", mem_address, 0);
    cpu_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_req("after_rst_0400", 1, 0, 15'h0400, 0, 7, 32'd1024, 4, 0);
    do_req("after_rst_1800", 1, 0, 15'h1800, 0, 7, 32'd6144, 4, 0);

    // Reset during WRITE_MEM drops mem_write immediately.
    @(posedge clk); #1;
    cpu_address   = 15'h0010;
    cpu_writeData = 32'h0BADF00D;
    cpu_write     = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_wr.mem_write_before", mem_write, 1);
    rst = 1'b1;
    #1;
    check("rst_wr.mem_write", mem_write, 0);
    check("rst_wr.mem_writeData", mem_writeData, 0);
`ifdef CACHE_STATS_EN
    check("rst_wr.miss_count", miss_count, 0);
`endif
    cpu_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
